// File: rtl/br_mask_ctrl_pkg.sv
// Shared project defines: branch-stack depth, rename widths and the branch-mask type.
package br_mask_ctrl_pkg;

   localparam int unsigned BR_NUM   = 4;
   localparam int unsigned MAP_W    = 6;
   localparam int unsigned FL_W     = 6;
   localparam int unsigned BR_CNT_W = $clog2(BR_NUM + 1);

   typedef logic [BR_NUM-1:0] br_mask_t;

endpackage

// File: rtl/br_first_zero_enc.sv
// Lowest-index zero finder: one-hot position of the first clear bit, or none when all set.
module br_first_zero_enc #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] vec,
   output logic [W-1:0] onehot,
   output logic         none
);

   always_comb begin
      onehot = '0;
      none   = 1'b1;
      for (int i = 0; i < W; i++) begin
         if (none && !vec[i]) begin
            onehot[i] = 1'b1;
            none      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/br_mask_ctrl.sv
// Branch-mask controller: allocates checkpoint tags, frees them on correct resolve,
// and drives checkpoint recovery and younger-branch squash on mispredict.
module br_mask_ctrl #(
   parameter int unsigned BR_NUM = br_mask_ctrl_pkg::BR_NUM
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dispatch_br_i,
   input  logic                         br_rs_valid_i,
   input  logic [BR_NUM-1:0]            br_rs_tag_i,
   input  logic                         br_rs_wrong_i,
   input  logic [BR_NUM-1:0]            br_rs_dep_mask_i,
   output logic [BR_NUM-1:0]            cur_mask_o,
   output logic [BR_NUM-1:0]            new_tag_o,
   output logic                         full_o,
   output logic                         rc_valid_o,
   output logic [BR_NUM-1:0]            rc_sel_o,
   output logic [BR_NUM-1:0]            squash_mask_o,
   output logic [$clog2(BR_NUM+1)-1:0]  br_cnt_o
);

   localparam int unsigned CNT_W = $clog2(BR_NUM + 1);

   logic [BR_NUM-1:0] mask_q;
   logic [BR_NUM-1:0] mask_d;
   logic [BR_NUM-1:0] grant_q;
   logic [BR_NUM-1:0] prev_q;
   logic [BR_NUM-1:0] clr;
   logic [BR_NUM-1:0] avail;
   logic [BR_NUM-1:0] fz_onehot;
   logic              fz_none;
   logic              hit;
   logic [CNT_W-1:0]  cnt;

   // A resolve only counts when its tag is still live
   assign hit        = |(br_rs_tag_i & mask_q);
   assign rc_valid_o = ~rst & br_rs_valid_i & br_rs_wrong_i & hit;
   assign clr        = (br_rs_valid_i & ~br_rs_wrong_i & hit) ? br_rs_tag_i : '0;
   assign avail      = mask_q & ~clr;

   br_first_zero_enc #(.W(BR_NUM)) u_first_zero (
      .vec    (avail),
      .onehot (fz_onehot),
      .none   (fz_none)
   );

   assign new_tag_o = (dispatch_br_i & ~full_o & ~rc_valid_o & ~rst & ~fz_none)
                      ? fz_onehot : '0;

   assign rc_sel_o      = rc_valid_o ? br_rs_tag_i : '0;
   assign squash_mask_o = rc_valid_o ? (mask_q & ~br_rs_dep_mask_i) : '0;

   // Recovery restores the mispredicted branch's dependency view; otherwise free then grant
   assign mask_d = rc_valid_o ? (br_rs_dep_mask_i & mask_q) : (avail | new_tag_o);

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q  <= '0;
         grant_q <= '0;
         prev_q  <= '0;
      end else begin
         mask_q  <= mask_d;
         grant_q <= new_tag_o;
         prev_q  <= mask_q;
         assert ($onehot0(mask_q & ~prev_q));
         assert ((mask_q & ~prev_q & ~grant_q) == '0);
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < BR_NUM; i++) begin
         cnt = cnt + CNT_W'(mask_q[i]);
      end
   end

   assign cur_mask_o = mask_q;
   assign full_o     = &mask_q;
   assign br_cnt_o   = cnt;

endmodule
